// File: rtl/mb_dot_accum_pkg.sv
// Shared definitions for the dot-product accumulator around mb32_top:
// controller state encoding, default operand width / multiplier latency,
// and the bit positions inside a pipeline tag.
package mb_dot_accum_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MULT_LAT = 3;

    // Tag layout: {v, last}
    localparam int TAG_V    = 1;
    localparam int TAG_LAST = 0;

endpackage

// File: rtl/mb_tag_pipe.sv
// Tag shift register that follows each accepted operand pair through the
// multiplier. A tag leaving the tail marks the cycle in which product1
// belongs to that pair. Empty (zero) tags fill the slots of input bubbles.
module mb_tag_pipe
    import mb_dot_accum_pkg::*;
#(
    parameter int DEPTH = DEF_MULT_LAT + 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out,
    output logic       any_v
);

    logic [1:0] pipe [DEPTH];

    // Advance every tag one stage per clock; stage 0 takes the new tag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_out = pipe[DEPTH-1];

    // Flag any pair still in flight through the multiplier
    always_comb begin
        any_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_v = any_v | pipe[i][TAG_V];
        end
    end

endmodule

// File: rtl/mb_dot_accum.sv
// Dot-product wrapper for mb32_top: registers operand pairs onto mx1/my1,
// tracks them through the fixed multiplier latency with a tag pipe, sums
// the returning products and hands out one result per VEC_LEN pairs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACCUM | accepting pairs, in_ready=1
// ST_DRAIN | all pairs accepted, waiting for the last product to return
// ST_HOLD  | result presented, waiting for res_ready
module mb_dot_accum
    import mb_dot_accum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MULT_LAT  = DEF_MULT_LAT,
    parameter int VEC_LEN   = 16,
    parameter int ACC_WIDTH = 72
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_x,
    input  logic [WIDTH-1:0]       in_y,
    output logic [WIDTH-1:0]       mx1,
    output logic [WIDTH-1:0]       my1,
    input  logic [2*WIDTH-1:0]     product1,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_WIDTH-1:0]   res_data,
    output logic                   res_ovf,
    output logic                   busy
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     elem_cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_acc;
    logic                 accept;
    logic                 in_last;
    logic [1:0]           tag_in;
    logic [1:0]           tag_tail;
    logic                 tag_any;
    logic                 cap_v;
    logic                 cap_last;
    logic [SUM_W-1:0]     sum;

    assign accept   = in_valid && in_ready;
    assign in_last  = (elem_cnt == LAST_IDX);
    assign tag_in   = {accept, accept && in_last};
    assign cap_v    = tag_tail[TAG_V];
    assign cap_last = tag_tail[TAG_LAST];
    // Extra top bit catches the carry out of the accumulator
    assign sum      = {1'b0, acc} + SUM_W'(product1);
    assign busy     = (state != ST_ACCUM) || tag_any;

    mb_tag_pipe #(
        .DEPTH (MULT_LAT + 1)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .tag_in  (tag_in),
        .tag_out (tag_tail),
        .any_v   (tag_any)
    );

    // Controller state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and in_ready decode
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cap_v && cap_last) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_valid && res_ready) begin
                    state_nxt = ST_ACCUM;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    // Register accepted operands for the multiplier and count pairs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mx1      <= '0;
            my1      <= '0;
            elem_cnt <= '0;
        end else if (accept) begin
            mx1      <= in_x;
            my1      <= in_y;
            elem_cnt <= in_last ? '0 : elem_cnt + CNT_W'(1);
        end
    end

    // Sum returning products; the last tag closes the vector into the result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (cap_v) begin
                if (cap_last) begin
                    res_data  <= sum[ACC_WIDTH-1:0];
                    res_ovf   <= ovf_acc | sum[ACC_WIDTH];
                    res_valid <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                end else begin
                    acc       <= sum[ACC_WIDTH-1:0];
                    ovf_acc   <= ovf_acc | sum[ACC_WIDTH];
                end
            end
            if (state == ST_HOLD && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mb_dot_accum.sv
// Bench for mb_dot_accum: three instances (VEC_LEN=4/ACC 72, VEC_LEN=16/ACC 72,
// VEC_LEN=2/ACC 64), each paired with a behavioural 3-stage multiplier.
module tb_mb_dot_accum;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic [2:0]     in_valid;
    logic [2:0]     in_ready;
    logic [2:0]     res_valid;
    logic [2:0]     res_ready;
    logic [2:0]     res_ovf;
    logic [2:0]     busy;
    logic [W-1:0]   in_x [3];
    logic [W-1:0]   in_y [3];
    logic [W-1:0]   mx1 [3];
    logic [W-1:0]   my1 [3];
    logic [2*W-1:0] product1 [3];
    logic [71:0]    rd0;
    logic [71:0]    rd1;
    logic [63:0]    rd2;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int last_acc = 0;
    logic rr_run = 1'b0;

    logic [72:0] rq0 [$];
    logic [72:0] rq1 [$];
    logic [72:0] rq2 [$];
    logic [72:0] exq [$];
    int          cq0 [$];
    logic [31:0] vx [$];
    logic [31:0] vy [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mb_dot_accum #(.WIDTH(32), .MULT_LAT(3), .VEC_LEN(4), .ACC_WIDTH(72)) dut_a (
        .CLK(CLK), .RST(RST), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_x(in_x[0]), .in_y(in_y[0]), .mx1(mx1[0]), .my1(my1[0]), .product1(product1[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(rd0),
        .res_ovf(res_ovf[0]), .busy(busy[0]));

    mb_dot_accum #(.WIDTH(32), .MULT_LAT(3), .VEC_LEN(16), .ACC_WIDTH(72)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_x(in_x[1]), .in_y(in_y[1]), .mx1(mx1[1]), .my1(my1[1]), .product1(product1[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(rd1),
        .res_ovf(res_ovf[1]), .busy(busy[1]));

    mb_dot_accum #(.WIDTH(32), .MULT_LAT(3), .VEC_LEN(2), .ACC_WIDTH(64)) dut_c (
        .CLK(CLK), .RST(RST), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_x(in_x[2]), .in_y(in_y[2]), .mx1(mx1[2]), .my1(my1[2]), .product1(product1[2]),
        .res_valid(res_valid[2]), .res_ready(res_ready[2]), .res_data(rd2),
        .res_ovf(res_ovf[2]), .busy(busy[2]));

    // Stand-in for mb32_top: product1 follows mx1/my1 by three clock edges
    for (genvar g = 0; g < 3; g++) begin : g_mult
        logic [63:0] s1, s2, s3;
        always @(posedge CLK) begin
            s1 <= 64'(mx1[g]) * 64'(my1[g]);
            s2 <= s1;
            s3 <= s2;
        end
        assign product1[g] = s3;
    end

    // Record every result handshake (values seen just before the edge)
    always @(posedge CLK) begin
        if (res_valid[0] && res_ready[0]) begin
            rq0.push_back({res_ovf[0], rd0});
            cq0.push_back(cyc);
        end
        if (res_valid[1] && res_ready[1]) rq1.push_back({res_ovf[1], rd1});
        if (res_valid[2] && res_ready[2]) rq2.push_back({res_ovf[2], 8'h00, rd2});
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int s);
        case (s)
            0:       return rq0.size();
            1:       return rq1.size();
            default: return rq2.size();
        endcase
    endfunction

    function automatic logic [72:0] qpop(input int s);
        logic [72:0] r;
        r = '0;
        case (s)
            0:       if (rq0.size() > 0) r = rq0.pop_front();
            1:       if (rq1.size() > 0) r = rq1.pop_front();
            default: if (rq2.size() > 0) r = rq2.pop_front();
        endcase
        return r;
    endfunction

    // Reference: exact sum of x*y, reduced to the accumulator width
    function automatic logic [72:0] model(input int accw);
        logic [79:0] full;
        logic [71:0] data;
        logic        ovf;
        full = '0;
        for (int i = 0; i < vx.size(); i++) begin
            full = full + 80'(vx[i]) * 80'(vy[i]);
        end
        if (accw == 64) begin
            data = 72'(full[63:0]);
            ovf  = |full[79:64];
        end else begin
            data = full[71:0];
            ovf  = |full[79:72];
        end
        return {ovf, data};
    endfunction

    task automatic load_const(input int n, input logic [31:0] x, input logic [31:0] y);
        vx.delete();
        vy.delete();
        for (int i = 0; i < n; i++) begin
            vx.push_back(x);
            vy.push_back(y);
        end
    endtask

    task automatic load_ramp(input logic [31:0] y);
        vx.delete();
        vy.delete();
        for (int i = 1; i <= 4; i++) begin
            vx.push_back(32'(i));
            vy.push_back(y);
        end
    endtask

    // Offer every pair in vx/vy to instance s; bub = bubble percentage
    task automatic send_vec(input int s, input int bub);
        int   tries;
        logic accepted;
        for (int i = 0; i < vx.size(); i++) begin
            tries    = 0;
            accepted = 1'b0;
            while (!accepted && tries < 400) begin
                @(negedge CLK);
                tries++;
                if (bub > 0 && $urandom_range(99) < bub) begin
                    in_valid[s] = 1'b0;
                    in_x[s]     = $urandom;
                    in_y[s]     = $urandom;
                end else begin
                    in_valid[s] = 1'b1;
                    in_x[s]     = vx[i];
                    in_y[s]     = vy[i];
                    if (in_ready[s]) begin
                        accepted = 1'b1;
                        last_acc = cyc + 1;
                    end
                end
            end
            if (!accepted) chk("accept_timeout", 80'(accepted), 80'd1);
        end
        @(negedge CLK);
        in_valid[s] = 1'b0;
    endtask

    task automatic wait_res(input int s, output logic [72:0] r);
        int t;
        t = 0;
        while (qsize(s) == 0 && t < 300) begin
            @(negedge CLK);
            t++;
        end
        chk("result_arrived", 80'(qsize(s) != 0), 80'd1);
        r = qpop(s);
    endtask

    initial begin
        logic [72:0] r;
        logic [72:0] e;
        int          t;
        int          nvec;

        in_valid  = '0;
        res_ready = '1;
        for (int i = 0; i < 3; i++) begin
            in_x[i] = '0;
            in_y[i] = '0;
        end
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_in_ready",  80'(in_ready),  80'h7);
        chk("rst_res_valid", 80'(res_valid), 80'h0);
        chk("rst_busy",      80'(busy),      80'h0);
        chk("rst_res_ovf",   80'(res_ovf),   80'h0);
        chk("rst_res_data",  80'(rd0),       80'h0);
        chk("rst_mx1",       80'(mx1[0]),    80'h0);
        RST = 1'b0;
        @(negedge CLK);

        // Test 1: 1..4 times 5, latency to res_valid
        load_ramp(32'd5);
        send_vec(0, 0);
        wait_res(0, r);
        chk("t1_data", 80'(r[71:0]), 80'd50);
        chk("t1_ovf",  80'(r[72]),   80'd0);
        chk("t1_latency", 80'(cq0.size() > 0 ? cq0.pop_front() : -1), 80'(last_acc + 4));
        @(negedge CLK);
        chk("t1_valid_one_cycle", 80'(res_valid[0]), 80'd0);
        chk("t1_idle_busy",       80'(busy[0]),      80'd0);
        chk("t1_in_ready",        80'(in_ready[0]),  80'd1);

        // Test 2: sixteen full-scale products
        load_const(16, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_vec(1, 0);
        wait_res(1, r);
        chk("t2_data", 80'(r[71:0]), 80'h0F_FFFF_FFE0_0000_0010);
        chk("t2_ovf",  80'(r[72]),   80'd0);

        // Test 3: overflow in a 64-bit accumulator, then a clean vector
        load_const(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_vec(2, 0);
        wait_res(2, r);
        chk("t3_data", 80'(r[71:0]), 80'h00_FFFF_FFFC_0000_0002);
        chk("t3_ovf",  80'(r[72]),   80'd1);
        load_const(2, 32'd1, 32'd1);
        send_vec(2, 0);
        wait_res(2, r);
        chk("t3_next_data", 80'(r[71:0]), 80'd2);
        chk("t3_next_ovf",  80'(r[72]),   80'd0);

        // Test 4: consumer stalls for 10 cycles, input offered meanwhile
        res_ready[0] = 1'b0;
        vx.delete();
        vy.delete();
        for (int i = 0; i < 4; i++) begin
            vx.push_back($urandom);
            vy.push_back($urandom);
        end
        e = model(72);
        send_vec(0, 0);
        t = 0;
        while (!res_valid[0] && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("t4_valid_seen", 80'(res_valid[0]), 80'd1);
        chk("t4_busy_hold",  80'(busy[0]),      80'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            in_x[0]     = $urandom;
            in_y[0]     = $urandom;
            @(negedge CLK);
            chk("t4_hold_data",     80'(rd0),          80'(e[71:0]));
            chk("t4_hold_ovf",      80'(res_ovf[0]),   80'(e[72]));
            chk("t4_hold_in_ready", 80'(in_ready[0]),  80'd0);
            chk("t4_hold_valid",    80'(res_valid[0]), 80'd1);
        end
        in_valid[0]  = 1'b0;
        res_ready[0] = 1'b1;
        @(negedge CLK);
        chk("t4_in_ready_after", 80'(in_ready[0]),  80'd1);
        chk("t4_valid_after",    80'(res_valid[0]), 80'd0);
        wait_res(0, r);
        chk("t4_data", 80'(r[71:0]), 80'(e[71:0]));
        chk("t4_single_result", 80'(rq0.size()), 80'd0);
        cq0.delete();

        // Test 5: bubbles, then reset mid-vector, then a clean vector
        load_ramp(32'd5);
        send_vec(0, 40);
        wait_res(0, r);
        chk("t5_bubble_data", 80'(r[71:0]), 80'd50);
        load_const(2, 32'd7, 32'd9);
        send_vec(0, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_rst_in_ready", 80'(in_ready[0]), 80'd1);
        chk("t5_rst_busy",     80'(busy[0]),     80'd0);
        RST = 1'b0;
        load_const(4, 32'd1, 32'd1);
        send_vec(0, 0);
        wait_res(0, r);
        chk("t5_clean_data", 80'(r[71:0]), 80'd4);
        chk("t5_clean_ovf",  80'(r[72]),   80'd0);
        chk("t5_no_partial", 80'(rq0.size()), 80'd0);
        cq0.delete();

        // Test 6: random vectors, random bubbles, random res_ready
        nvec   = 1500;
        rr_run = 1'b1;
        fork
            while (rr_run) begin
                @(negedge CLK);
                res_ready[0] = 1'($urandom_range(1));
            end
        join_none
        for (int v = 0; v < nvec; v++) begin
            vx.delete();
            vy.delete();
            for (int i = 0; i < 4; i++) begin
                vx.push_back($urandom);
                vy.push_back($urandom);
            end
            exq.push_back(model(72));
            send_vec(0, 25);
        end
        rr_run = 1'b0;
        repeat (2) @(negedge CLK);
        res_ready[0] = 1'b1;
        t = 0;
        while (rq0.size() < nvec && t < 500) begin
            @(negedge CLK);
            t++;
        end
        repeat (4) @(negedge CLK);
        chk("t6_result_count", 80'(rq0.size()), 80'(nvec));
        while (rq0.size() > 0 && exq.size() > 0) begin
            r = rq0.pop_front();
            e = exq.pop_front();
            chk("t6_data", 80'(r[71:0]), 80'(e[71:0]));
            chk("t6_ovf",  80'(r[72]),   80'(e[72]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
